matmul_8x8_c_writeback: RTL and testbench

Downstream stage of the 8x8 systolic matmul. It accepts the two right-column C output streams (tile 0_1 and tile 1_1). Each stream delivers one 4-element row per valid cycle, with its C address. Each stream is buffered in its own FIFO, and the block serializes both streams onto a single write port of the C memory. Back-pressure from the memory is absorbed without losing rows, and the block reports completion once all 8 rows of the 8x8 result are written.

---
 rtl/matmul_8x8_c_writeback.sv | 198 +++++++++++++++++++
 tb/tb_matmul_8x8_c_writeback.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_8x8_c_writeback.sv
// ---------------------------------------------------------------------------
// matmul_8x8_c_writeback
//
// Write-back stage for the right-column C outputs of the 8x8 systolic matmul.
// Rows from tile 0_1 and tile 1_1 are each buffered in a small FIFO and then
// serialized, round-robin, onto the single C memory write port. Memory
// back-pressure is absorbed by the FIFOs. A one-cycle done pulse is produced
// once TOTAL_ROWS rows have been written and both FIFOs are empty.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start_wb              one-cycle pulse arming the block for a new result
//   done_mat_mul          compute-done indication from the array
//   c_data/addr/available row stream from tile 0_1 and from tile 1_1
//   c_mem_wr_en/addr/wdata write request towards the C memory
//   c_mem_ready           memory accepts the write this cycle
//   wb_busy               high while ACTIVE or DRAIN
//   wb_done               one-cycle completion pulse
//   wb_overflow           sticky, a captured row was dropped
//   rows_written          accepted writes since start_wb (saturates at 15)
// ---------------------------------------------------------------------------
module matmul_8x8_c_writeback #(
  parameter int DWIDTH          = 8,
  parameter int AWIDTH          = 11,
  parameter int BB_MAT_MUL_SIZE = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int TOTAL_ROWS      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_wb,
  input  logic                              done_mat_mul,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_0_1,
  input  logic [AWIDTH-1:0]                 c_addr_0_1,
  input  logic                              c_data_0_1_available,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_1_1,
  input  logic [AWIDTH-1:0]                 c_addr_1_1,
  input  logic                              c_data_1_1_available,
  output logic                              c_mem_wr_en,
  output logic [AWIDTH-1:0]                 c_mem_addr,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_mem_wdata,
  input  logic                              c_mem_ready,
  output logic                              wb_busy,
  output logic                              wb_done,
  output logic                              wb_overflow,
  output logic [3:0]                        rows_written
);

  localparam int ROW_W = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int ENT_W = AWIDTH + ROW_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Per-tile FIFO storage and bookkeeping; index 0 is tile 0_1, 1 is tile 1_1.
  logic [ENT_W-1:0] fifo_mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [CNT_W-1:0] count_q  [2];
  logic [ENT_W-1:0] in_word  [2];

  logic [1:0] avail, empty, full, push, pop;
  logic       capture_en, issue_en, drop_any;
  logic       sel, wr_en, accept, all_done, clear_run;
  logic       rr_q, pending_q, lock_q;
  logic       overflow_q, done_seen_q;
  logic [3:0] rows_q;
  logic [ENT_W-1:0] head;

  assign avail      = {c_data_1_1_available, c_data_0_1_available};
  assign in_word[0] = {c_addr_0_1, c_data_0_1};
  assign in_word[1] = {c_addr_1_1, c_data_1_1};

  assign capture_en = (state_q != S_IDLE);
  assign issue_en   = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
  assign clear_run  = (state_q == S_IDLE) && start_wb;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first or full coverage) so no latch is inferred.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (count_q[i] == '0);
      full[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  // While a request is stalled the chosen FIFO is locked so that address,
  // data and wr_en stay stable even if the other FIFO fills up meanwhile.
  always_comb begin
    sel = rr_q;
    if (pending_q)                 sel = lock_q;
    else if (!empty[0] && empty[1]) sel = 1'b0;
    else if (empty[0] && !empty[1]) sel = 1'b1;
  end

  assign head   = fifo_mem[sel][rd_ptr_q[sel]];
  assign wr_en  = issue_en && !empty[sel];
  assign accept = wr_en && c_mem_ready;

  // A push into a full FIFO still succeeds when the same FIFO pops this edge.
  always_comb begin
    pop      = '0;
    push     = '0;
    drop_any = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pop[i]  = accept && (sel == 1'(i));
      push[i] = capture_en && avail[i] && (!full[i] || pop[i]);
      if (capture_en && avail[i] && full[i] && !pop[i]) drop_any = 1'b1;
    end
  end

  assign all_done = empty[0] && empty[1] && (rows_q == 4'(TOTAL_ROWS));

  // NOTE: FIFO storage has no reset; emptiness is carried by the reset
  // pointers and counts, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= in_word[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
        count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_wb) state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (all_done)                         state_d = S_DONE;
        else if (done_mat_mul || done_seen_q) state_d = S_DRAIN;
      end
      S_DRAIN:  if (all_done) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      pending_q   <= 1'b0;
      lock_q      <= 1'b0;
      rows_q      <= '0;
      overflow_q  <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= wr_en && !c_mem_ready;
      lock_q    <= sel;
      if (accept) rr_q <= ~rr_q;

      if (clear_run)                   rows_q <= '0;
      else if (accept && rows_q != 4'hF) rows_q <= rows_q + 4'd1;

      if (clear_run)     overflow_q <= 1'b0;
      else if (drop_any) overflow_q <= 1'b1;

      if (clear_run)                                 done_seen_q <= 1'b0;
      else if (state_q == S_ACTIVE && done_mat_mul) done_seen_q <= 1'b1;
    end
  end

  assign c_mem_wr_en  = wr_en;
  assign c_mem_addr   = wr_en ? head[ENT_W-1 -: AWIDTH] : '0;
  assign c_mem_wdata  = wr_en ? head[ROW_W-1:0]         : '0;
  assign wb_busy      = issue_en;
  assign wb_done      = (state_q == S_DONE);
  assign wb_overflow  = overflow_q;
  assign rows_written = rows_q;

endmodule

// File: tb/tb_matmul_8x8_c_writeback.sv
// ---------------------------------------------------------------------------
// tb_matmul_8x8_c_writeback
//
// Directed bench for the C write-back stage: a cycle table for the basic
// interleaved traffic, plus hand-written sequences for back-pressure, FIFO
// overflow, single-stream latency, reset mid-stream and IDLE inputs.
// ---------------------------------------------------------------------------
module tb_matmul_8x8_c_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_wb;
  logic        done_mat_mul;
  logic [31:0] c_data_0_1;
  logic [10:0] c_addr_0_1;
  logic        c_data_0_1_available;
  logic [31:0] c_data_1_1;
  logic [10:0] c_addr_1_1;
  logic        c_data_1_1_available;
  logic        c_mem_wr_en;
  logic [10:0] c_mem_addr;
  logic [31:0] c_mem_wdata;
  logic        c_mem_ready;
  logic        wb_busy;
  logic        wb_done;
  logic        wb_overflow;
  logic [3:0]  rows_written;

  int checks = 0;
  int errors = 0;

  matmul_8x8_c_writeback dut (
    .clk                  (clk),
    .reset                (reset),
    .start_wb             (start_wb),
    .done_mat_mul         (done_mat_mul),
    .c_data_0_1           (c_data_0_1),
    .c_addr_0_1           (c_addr_0_1),
    .c_data_0_1_available (c_data_0_1_available),
    .c_data_1_1           (c_data_1_1),
    .c_addr_1_1           (c_addr_1_1),
    .c_data_1_1_available (c_data_1_1_available),
    .c_mem_wr_en          (c_mem_wr_en),
    .c_mem_addr           (c_mem_addr),
    .c_mem_wdata          (c_mem_wdata),
    .c_mem_ready          (c_mem_ready),
    .wb_busy              (wb_busy),
    .wb_done              (wb_done),
    .wb_overflow          (wb_overflow),
    .rows_written         (rows_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        a0;
    logic [10:0] ad0;
    logic        a1;
    logic [10:0] ad1;
    logic        rdy;
    logic        dn;
    logic        e_wr;
    logic [10:0] e_addr;
    logic        e_busy;
    logic        e_done;
    logic [3:0]  e_rows;
  } vec_t;

  // Row payload is a fixed scramble of the address so data and address can
  // be checked against each other.
  function automatic logic [31:0] mk_data(input logic [10:0] a);
    return {5'b10100, a[10:8], a[7:0], ~a[7:0], a[7:0] ^ 8'h3C};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic st, input logic a0, input logic [10:0] ad0,
                        input logic a1, input logic [10:0] ad1,
                        input logic rdy, input logic dn);
    start_wb             = st;
    c_data_0_1_available = a0;
    c_addr_0_1           = ad0;
    c_data_0_1           = mk_data(ad0);
    c_data_1_1_available = a1;
    c_addr_1_1           = ad1;
    c_data_1_1           = mk_data(ad1);
    c_mem_ready          = rdy;
    done_mat_mul         = dn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t basic [13];

  initial begin
    logic [10:0] got_addr [$];
    logic [31:0] got_data [$];
    logic [10:0] exp_bp [8];
    logic [10:0] prev_addr;
    logic [31:0] prev_data;
    logic        prev_stall;
    int          stalls, pulses, done_cyc;

    //          st    a0    ad0      a1    ad1      rdy   dn    wr    addr     busy  done  rows
    basic[0]  = '{1'b1, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 4'd0};
    basic[1]  = '{1'b0, 1'b1, 11'h010, 1'b1, 11'h014, 1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 4'd0};
    basic[2]  = '{1'b0, 1'b1, 11'h011, 1'b1, 11'h015, 1'b1, 1'b0, 1'b1, 11'h010, 1'b1, 1'b0, 4'd0};
    basic[3]  = '{1'b0, 1'b1, 11'h012, 1'b1, 11'h016, 1'b1, 1'b0, 1'b1, 11'h014, 1'b1, 1'b0, 4'd1};
    basic[4]  = '{1'b0, 1'b1, 11'h013, 1'b1, 11'h017, 1'b1, 1'b0, 1'b1, 11'h011, 1'b1, 1'b0, 4'd2};
    basic[5]  = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b1, 1'b1, 11'h015, 1'b1, 1'b0, 4'd3};
    basic[6]  = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h012, 1'b1, 1'b0, 4'd4};
    basic[7]  = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h016, 1'b1, 1'b0, 4'd5};
    basic[8]  = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h013, 1'b1, 1'b0, 4'd6};
    basic[9]  = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 11'h017, 1'b1, 1'b0, 4'd7};
    basic[10] = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0, 4'd8};
    basic[11] = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1, 4'd8};
    basic[12] = '{1'b0, 1'b0, 11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 4'd8};

    exp_bp = '{11'h010, 11'h014, 11'h011, 11'h015, 11'h012, 11'h016, 11'h013, 11'h017};

    reset = 1'b1;
    set_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0);
    #1;
    check("reset_wr_en", c_mem_wr_en, 0);
    check("reset_addr", c_mem_addr, 0);
    check("reset_wdata", c_mem_wdata, 0);
    check("reset_busy", wb_busy, 0);
    check("reset_done", wb_done, 0);
    check("reset_overflow", wb_overflow, 0);
    check("reset_rows", rows_written, 0);
    do_reset();

    // IDLE inputs: rows and done_mat_mul without start_wb are discarded.
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      set_in(cyc == 4, cyc < 4, 11'h100, cyc < 4, 11'h104, 1'b1, cyc < 4);
      #1;
      check("idle_wr_en", c_mem_wr_en, 0);
      if (cyc < 5) begin
        check("idle_busy", wb_busy, 0);
        check("idle_overflow", wb_overflow, 0);
      end else begin
        check("idle_then_start_busy", wb_busy, 1);
      end
    end

    // Basic interleaved traffic from the table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_in(basic[i].st, basic[i].a0, basic[i].ad0, basic[i].a1, basic[i].ad1,
             basic[i].rdy, basic[i].dn);
      #1;
      check($sformatf("basic_wr_en[%0d]", i), c_mem_wr_en, basic[i].e_wr);
      check($sformatf("basic_addr[%0d]", i), c_mem_addr, basic[i].e_addr);
      check($sformatf("basic_wdata[%0d]", i), c_mem_wdata,
            basic[i].e_wr ? mk_data(basic[i].e_addr) : 32'h0);
      check($sformatf("basic_busy[%0d]", i), wb_busy, basic[i].e_busy);
      check($sformatf("basic_done[%0d]", i), wb_done, basic[i].e_done);
      check($sformatf("basic_rows[%0d]", i), rows_written, basic[i].e_rows);
    end
    check("basic_overflow", wb_overflow, 0);

    // Back-pressure: ready low for cycles 4..6 in the middle of the stream.
    do_reset();
    got_addr.delete();
    got_data.delete();
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    stalls     = 0;
    pulses     = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      set_in(cyc == 0, cyc >= 1 && cyc <= 4, 11'(16 + cyc - 1),
             cyc >= 1 && cyc <= 4, 11'(20 + cyc - 1),
             !(cyc >= 4 && cyc <= 6), cyc == 5);
      #1;
      if (prev_stall) begin
        check("bp_hold_wr_en", c_mem_wr_en, 1);
        check("bp_hold_addr", c_mem_addr, prev_addr);
        check("bp_hold_wdata", c_mem_wdata, prev_data);
      end
      if (c_mem_wr_en && c_mem_ready) begin
        got_addr.push_back(c_mem_addr);
        got_data.push_back(c_mem_wdata);
      end
      if (c_mem_wr_en && !c_mem_ready) stalls++;
      if (wb_done) pulses++;
      prev_stall = c_mem_wr_en && !c_mem_ready;
      prev_addr  = c_mem_addr;
      prev_data  = c_mem_wdata;
    end
    check("bp_stall_cycles", stalls, 3);
    check("bp_write_count", got_addr.size(), 8);
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      check($sformatf("bp_order[%0d]", i), got_addr[i], exp_bp[i]);
      check($sformatf("bp_data[%0d]", i), got_data[i], mk_data(exp_bp[i]));
    end
    check("bp_done_pulses", pulses, 1);
    check("bp_rows", rows_written, 8);
    check("bp_overflow", wb_overflow, 0);

    // Overflow: five rows into a four-deep FIFO while the memory is stalled.
    do_reset();
    got_addr.delete();
    pulses = 0;
    for (int cyc = 0; cyc < 17; cyc++) begin
      @(negedge clk);
      set_in(cyc == 0, cyc >= 1 && cyc <= 5, 11'(32 + cyc - 1), 1'b0, 11'h0,
             cyc >= 7, cyc == 7);
      #1;
      if (cyc == 5) check("ovf_full_not_yet", wb_overflow, 0);
      if (cyc == 6) begin
        check("ovf_set", wb_overflow, 1);
        check("ovf_stalled_addr", c_mem_addr, 11'h020);
      end
      if (c_mem_wr_en && c_mem_ready) got_addr.push_back(c_mem_addr);
      if (wb_done) pulses++;
    end
    check("ovf_write_count", got_addr.size(), 4);
    for (int i = 0; i < 4 && i < got_addr.size(); i++)
      check($sformatf("ovf_order[%0d]", i), got_addr[i], 11'(32 + i));
    check("ovf_sticky", wb_overflow, 1);
    check("ovf_rows", rows_written, 4);
    check("ovf_stuck_drain", wb_busy, 1);
    check("ovf_no_done", pulses, 0);

    // Reset mid-stream after three writes.
    do_reset();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      set_in(cyc == 0, cyc >= 1, 11'(64 + cyc - 1), 1'b0, 11'h0, 1'b1, 1'b0);
      #1;
    end
    check("rst_mid_rows_before", rows_written, 3);
    check("rst_mid_addr_before", c_mem_addr, 11'h043);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wr_en", c_mem_wr_en, 0);
    check("rst_mid_addr", c_mem_addr, 0);
    check("rst_mid_wdata", c_mem_wdata, 0);
    check("rst_mid_busy", wb_busy, 0);
    check("rst_mid_rows", rows_written, 0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    set_in(1'b1, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      set_in(1'b0, 1'b0, 11'h0, 1'b0, 11'h0, 1'b1, 1'b0);
      #1;
      check("rst_restart_rows", rows_written, 0);
      check("rst_restart_empty", c_mem_wr_en, 0);
      check("rst_restart_busy", wb_busy, 1);
    end

    // Single stream: tile 1_1 only, each row written the cycle after capture.
    do_reset();
    pulses   = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      set_in(cyc == 0, 1'b0, 11'h0, cyc >= 1 && cyc <= 8, 11'(48 + cyc - 1),
             1'b1, cyc == 8);
      #1;
      if (cyc >= 2 && cyc <= 9) begin
        check($sformatf("single_wr_en[%0d]", cyc), c_mem_wr_en, 1);
        check($sformatf("single_addr[%0d]", cyc), c_mem_addr, 11'(48 + cyc - 2));
      end
      if (cyc == 10) check("single_idle_after", c_mem_wr_en, 0);
      if (wb_done) begin
        pulses++;
        done_cyc = cyc;
      end
    end
    check("single_done_pulses", pulses, 1);
    check("single_done_cycle", done_cyc, 11);
    check("single_rows", rows_written, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
